// File: rtl/jk_excitation_driver.sv
// Steps an external bank of JK flip-flops to a requested word: one drive cycle, one
// check cycle against the fed-back Q, and up to MAX_RETRY re-drives before flagging ERR.
module jk_excitation_driver #(
    parameter int WIDTH       = 8,
    parameter int MAX_RETRY   = 3,
    parameter int TOGGLE_MODE = 0,
    localparam int RW         = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             TGT_VALID,
    output logic             TGT_READY,
    input  logic [WIDTH-1:0] TGT_DATA,
    input  logic [WIDTH-1:0] Q_FB,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    output logic [RW-1:0]    RETRY_CNT
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    localparam logic [RW-1:0] MAX_RETRY_C = RW'(MAX_RETRY);
    localparam logic [RW-1:0] ONE_C       = RW'(1'b1);

    state_t            state_r;
    logic [WIDTH-1:0]  tgt_r;
    logic [RW-1:0]     retry_r;
    logic              busy_r;
    logic              done_r;
    logic              err_r;
    logic [WIDTH-1:0]  set_s;
    logic [WIDTH-1:0]  clr_s;
    logic [WIDTH-1:0]  diff_s;
    logic [WIDTH-1:0]  j_s;
    logic [WIDTH-1:0]  k_s;

    // Request sequencing, retry accounting and the DONE/ERR pulses.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
            tgt_r   <= {WIDTH{1'b0}};
            retry_r <= {RW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (TGT_VALID && TGT_READY) begin
                        tgt_r   <= TGT_DATA;
                        retry_r <= {RW{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    state_r <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (Q_FB == tgt_r) begin
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else if (retry_r < MAX_RETRY_C) begin
                        retry_r <= retry_r + ONE_C;
                        state_r <= ST_DRIVE;
                    end else begin
                        err_r   <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Excitation follows the live Q so every retry re-targets only the bits still wrong.
    always_comb begin
        set_s  = tgt_r & ~Q_FB;
        clr_s  = ~tgt_r & Q_FB;
        diff_s = tgt_r ^ Q_FB;
        j_s    = {WIDTH{1'b0}};
        k_s    = {WIDTH{1'b0}};
        if ((state_r == ST_DRIVE) && !RST) begin
            if (TOGGLE_MODE != 0) begin
                j_s = diff_s;
                k_s = diff_s;
            end else begin
                j_s = set_s;
                k_s = clr_s;
            end
        end else begin
            j_s = {WIDTH{1'b0}};
            k_s = {WIDTH{1'b0}};
        end
    end

    assign TGT_READY = (state_r == ST_IDLE) && !RST;
    assign J         = j_s;
    assign K         = k_s;
    assign BUSY      = busy_r;
    assign DONE      = done_r;
    assign ERR       = err_r;
    assign RETRY_CNT = retry_r;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver: two instances (set/reset and toggle) each feeding a
// behavioural JK bank; request outcomes go through a scoreboard queue per instance.
module tb_jk_excitation_driver;
    localparam int WIDTH     = 8;
    localparam int MAX_RETRY = 3;
    localparam int RW        = 2;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic             RST       = 1'b1;
    logic             TGT_VALID = 1'b0;
    logic [WIDTH-1:0] TGT_DATA  = 8'h00;

    logic             rdy0, busy0, done0, err0;
    logic [WIDTH-1:0] j0, k0;
    logic [RW-1:0]    rc0;
    logic [WIDTH-1:0] q0     = 8'h00;
    logic             load0  = 1'b0;
    logic [WIDTH-1:0] init0  = 8'h00;
    logic [WIDTH-1:0] stuck0 = 8'h00;

    logic             rdy1, busy1, done1, err1;
    logic [WIDTH-1:0] j1, k1;
    logic [RW-1:0]    rc1;
    logic [WIDTH-1:0] q1     = 8'h00;
    logic             load1  = 1'b0;
    logic [WIDTH-1:0] init1  = 8'h00;

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic             is_err;
        logic [RW-1:0]    rc;
        int               due;
        logic [WIDTH-1:0] q;
    } exp_t;
    exp_t exp0_q[$];
    exp_t exp1_q[$];
    exp_t e;

    jk_excitation_driver #(.WIDTH(WIDTH), .MAX_RETRY(MAX_RETRY), .TOGGLE_MODE(0)) dut (
        .CLK(CLK), .RST(RST), .TGT_VALID(TGT_VALID), .TGT_READY(rdy0), .TGT_DATA(TGT_DATA),
        .Q_FB(q0), .J(j0), .K(k0), .BUSY(busy0), .DONE(done0), .ERR(err0), .RETRY_CNT(rc0)
    );

    jk_excitation_driver #(.WIDTH(WIDTH), .MAX_RETRY(MAX_RETRY), .TOGGLE_MODE(1)) dut_t (
        .CLK(CLK), .RST(RST), .TGT_VALID(TGT_VALID), .TGT_READY(rdy1), .TGT_DATA(TGT_DATA),
        .Q_FB(q1), .J(j1), .K(k1), .BUSY(busy1), .DONE(done1), .ERR(err1), .RETRY_CNT(rc1)
    );

    // JK characteristic equation Q+ = J&~Q | ~K&Q, with optional stuck-at-0 bits on bank 0.
    always @(posedge CLK) begin
        q0  <= load0 ? init0 : (((j0 & ~q0) | (~k0 & q0)) & ~stuck0);
        q1  <= load1 ? init1 : ((j1 & ~q1) | (~k1 & q1));
        cyc <= cyc + 1;
    end

    task automatic test_reset();
        RST = 1'b1; TGT_VALID = 1'b1; TGT_DATA = 8'h55;
        load0 = 1'b1; init0 = 8'h00; load1 = 1'b1; init1 = 8'h00;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        n_cmp++;
        if (rdy0 !== 1'b0 || j0 !== 8'h00 || k0 !== 8'h00 || busy0 !== 1'b0 ||
            done0 !== 1'b0 || err0 !== 1'b0 || rc0 !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_state: rdy=%b J=%h K=%h busy=%b done=%b err=%b rc=%0d required all 0",
                     rdy0, j0, k0, busy0, done0, err0, rc0);
        end
        @(posedge CLK); #1;
        RST = 1'b0; TGT_VALID = 1'b0; load0 = 1'b0; load1 = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (rdy0 !== 1'b1 || busy0 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: rdy=%b busy=%b required rdy=1 busy=0", rdy0, busy0);
        end
    endtask

    task automatic test_set_reset();
        int  c;
        bit  found;
        @(posedge CLK); #1;
        TGT_VALID = 1'b1; TGT_DATA = 8'hA5; c = cyc;
        exp0_q.push_back('{1'b0, 2'd0, c + 3, 8'hA5});
        @(posedge CLK); #1;
        TGT_VALID = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (j0 !== 8'hA5 || k0 !== 8'h00) begin
            n_bad++;
            $display("FAIL sr_drive_jk: J=%h K=%h required J=a5 K=00", j0, k0);
        end
        @(negedge CLK);
        n_cmp++;
        if (q0 !== 8'hA5 || j0 !== 8'h00 || k0 !== 8'h00 || done0 !== 1'b0) begin
            n_bad++;
            $display("FAIL sr_check_cycle: Q=%h J=%h K=%h done=%b required Q=a5 J=K=00 done=0",
                     q0, j0, k0, done0);
        end
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge CLK);
            if (done0 || err0) found = 1'b1;
        end
        e = exp0_q.pop_front();
        n_cmp++;
        if (!found || done0 !== ~e.is_err || err0 !== e.is_err || cyc !== e.due ||
            rc0 !== e.rc || q0 !== e.q) begin
            n_bad++;
            $display("FAIL sr_outcome: found=%b done=%b err=%b cyc=%0d rc=%0d Q=%h required done=%b err=%b cyc=%0d rc=%0d Q=%h",
                     found, done0, err0, cyc, rc0, q0, ~e.is_err, e.is_err, e.due, e.rc, e.q);
        end
    endtask

    task automatic test_toggle();
        int  c;
        bit  found;
        @(posedge CLK); #1;
        TGT_VALID = 1'b1; TGT_DATA = 8'h0F; load1 = 1'b1; init1 = 8'hF0; c = cyc;
        exp1_q.push_back('{1'b0, 2'd0, c + 3, 8'h0F});
        exp0_q.push_back('{1'b0, 2'd0, c + 3, 8'h0F});
        @(posedge CLK); #1;
        TGT_VALID = 1'b0; load1 = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (j1 !== 8'hFF || k1 !== 8'hFF) begin
            n_bad++;
            $display("FAIL tg_drive_jk: J=%h K=%h required J=ff K=ff", j1, k1);
        end
        n_cmp++;
        if (j0 !== 8'h0A || k0 !== 8'hA0) begin
            n_bad++;
            $display("FAIL sr_partial_jk: J=%h K=%h required J=0a K=a0", j0, k0);
        end
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge CLK);
            if (done1 || err1) found = 1'b1;
        end
        e = exp1_q.pop_front();
        n_cmp++;
        if (!found || done1 !== ~e.is_err || err1 !== e.is_err || cyc !== e.due ||
            rc1 !== e.rc || q1 !== e.q) begin
            n_bad++;
            $display("FAIL tg_outcome: found=%b done=%b err=%b cyc=%0d rc=%0d Q=%h required done=%b err=%b cyc=%0d rc=%0d Q=%h",
                     found, done1, err1, cyc, rc1, q1, ~e.is_err, e.is_err, e.due, e.rc, e.q);
        end
        e = exp0_q.pop_front();
        n_cmp++;
        if (done0 !== ~e.is_err || err0 !== e.is_err || cyc !== e.due || rc0 !== e.rc || q0 !== e.q) begin
            n_bad++;
            $display("FAIL sr_second_outcome: done=%b err=%b cyc=%0d rc=%0d Q=%h required done=%b err=%b cyc=%0d rc=%0d Q=%h",
                     done0, err0, cyc, rc0, q0, ~e.is_err, e.is_err, e.due, e.rc, e.q);
        end
    endtask

    task automatic test_retry_exhaust();
        int  c;
        int  drives;
        bit  found;
        bit  bad_jk;
        @(posedge CLK); #1;
        TGT_VALID = 1'b1; TGT_DATA = 8'h08; load0 = 1'b1; init0 = 8'h00; stuck0 = 8'h08; c = cyc;
        exp0_q.push_back('{1'b1, 2'd3, c + 1 + 2 * (MAX_RETRY + 1), 8'h00});
        @(posedge CLK); #1;
        TGT_VALID = 1'b0; load0 = 1'b0;
        drives = 0; bad_jk = 1'b0; found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge CLK);
            if (j0 !== 8'h00 || k0 !== 8'h00) begin
                drives++;
                if (j0 !== 8'h08 || k0 !== 8'h00) bad_jk = 1'b1;
            end
            if (done0 || err0) found = 1'b1;
        end
        e = exp0_q.pop_front();
        n_cmp++;
        if (!found || done0 !== ~e.is_err || err0 !== e.is_err || cyc !== e.due ||
            rc0 !== e.rc || q0 !== e.q) begin
            n_bad++;
            $display("FAIL retry_outcome: found=%b done=%b err=%b cyc=%0d rc=%0d Q=%h required done=%b err=%b cyc=%0d rc=%0d Q=%h",
                     found, done0, err0, cyc, rc0, q0, ~e.is_err, e.is_err, e.due, e.rc, e.q);
        end
        n_cmp++;
        if (drives !== 4 || bad_jk) begin
            n_bad++;
            $display("FAIL retry_drives: drives=%0d bad_jk=%b required drives=4 bad_jk=0", drives, bad_jk);
        end
        @(negedge CLK);
        n_cmp++;
        if (err0 !== 1'b0 || done0 !== 1'b0 || rc0 !== 2'd3 || busy0 !== 1'b0) begin
            n_bad++;
            $display("FAIL retry_after: err=%b done=%b rc=%0d busy=%b required err=0 done=0 rc=3 busy=0",
                     err0, done0, rc0, busy0);
        end
    endtask

    task automatic test_reset_mid();
        bit pulse;
        // Bit 3 stays stuck so the first check misses and a retry is in flight when reset hits.
        @(posedge CLK); #1;
        TGT_VALID = 1'b1; TGT_DATA = 8'h3C;
        @(posedge CLK); #1;
        TGT_VALID = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(negedge CLK);
        n_cmp++;
        if (busy0 !== 1'b1 || rc0 !== 2'd1 || rdy0 !== 1'b0 || j0 !== 8'h00) begin
            n_bad++;
            $display("FAIL rst_mid_pre: busy=%b rc=%0d rdy=%b J=%h required busy=1 rc=1 rdy=0 J=00",
                     busy0, rc0, rdy0, j0);
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || err0 !== 1'b0 || rc0 !== 2'd0 ||
            j0 !== 8'h00 || k0 !== 8'h00 || rdy0 !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_post: busy=%b done=%b err=%b rc=%0d J=%h K=%h rdy=%b required 0 0 0 0 00 00 1",
                     busy0, done0, err0, rc0, j0, k0, rdy0);
        end
        pulse = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            if (done0 || err0 || busy0) pulse = 1'b1;
        end
        n_cmp++;
        if (pulse) begin
            n_bad++;
            $display("FAIL rst_mid_quiet: activity=%b required 0", pulse);
        end
        stuck0 = 8'h00;
    endtask

    task automatic test_back_to_back();
        int  c;
        bit  found;
        @(posedge CLK); #1;
        TGT_VALID = 1'b1; TGT_DATA = 8'h11; c = cyc;
        exp0_q.push_back('{1'b0, 2'd0, c + 3, 8'h11});
        exp0_q.push_back('{1'b0, 2'd0, c + 6, 8'h22});
        @(posedge CLK); #1;
        TGT_DATA = 8'h22;
        for (int n = 0; n < 2; n++) begin
            found = 1'b0;
            for (int i = 0; i < 20 && !found; i++) begin
                @(negedge CLK);
                if (done0 || err0) found = 1'b1;
            end
            e = exp0_q.pop_front();
            n_cmp++;
            if (!found || done0 !== ~e.is_err || err0 !== e.is_err || cyc !== e.due ||
                rc0 !== e.rc || q0 !== e.q || rdy0 !== 1'b1) begin
                n_bad++;
                $display("FAIL b2b_outcome_%0d: found=%b done=%b err=%b cyc=%0d rc=%0d Q=%h rdy=%b required done=%b err=%b cyc=%0d rc=%0d Q=%h rdy=1",
                         n, found, done0, err0, cyc, rc0, q0, rdy0, ~e.is_err, e.is_err, e.due, e.rc, e.q);
            end
            @(posedge CLK); #1;
            TGT_VALID = 1'b0;
        end
        @(negedge CLK);
        n_cmp++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || exp0_q.size() != 0) begin
            n_bad++;
            $display("FAIL b2b_idle: busy=%b done=%b pending=%0d required 0 0 0",
                     busy0, done0, exp0_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_set_reset();
        test_toggle();
        test_retry_exhaust();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
